// File: rtl/ci_mul_pkg.sv
// ---------------------------------------------------------------------------
// ci_mul_pkg
// Shared definitions for the sequential shift-add multiplier custom
// instruction: FSM state encoding, default operand width and the helper that
// sizes the iteration counter.
// ---------------------------------------------------------------------------
package ci_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Bits needed to hold the values 0..width (the counter is loaded with width).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ci_mul_shift_add.sv
// ---------------------------------------------------------------------------
// ci_mul_shift_add
// Radix-2 shift-add datapath: accumulator, left-shifting multiplicand,
// right-shifting multiplier and iteration counter. One multiplier bit is
// consumed per enabled step.
//
// Parameters
//   WIDTH  operand width
//   PW     accumulator / product width (WIDTH for low word only, 2*WIDTH
//          when the high word is needed)
// Ports
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset
//   en      in   clock enable; all state holds when low
//   load    in   latch operands, clear accumulator, load counter with WIDTH
//   step    in   perform one shift-add iteration
//   dataa   in   multiplicand
//   datab   in   multiplier
//   last    out  counter is 1: the current step is the final iteration
//   prod_d  out  accumulator value after the current edge (next-state)
// ---------------------------------------------------------------------------
module ci_mul_shift_add
    import ci_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int PW    = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             last,
    output logic [PW-1:0]    prod_d
);

    localparam int CW = cnt_width(WIDTH);

    logic [PW-1:0]    acc_q,    acc_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = PW'(dataa);
            mplier_d = datab;
            cnt_d    = CW'(WIDTH);
        end else if (step) begin
            // No early exit on a zero multiplier: latency stays constant.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            // Bits shifted out of a WIDTH-wide multiplicand only affect the
            // high word, which is not kept in the narrow build.
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (en) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last   = (cnt_q == CW'(1));
    assign prod_d = acc_d;

endmodule

// File: rtl/ci_mul_seq.sv
// ---------------------------------------------------------------------------
// ci_mul_seq
// Multi-cycle Nios II custom instruction computing dataa*datab (unsigned) with
// a radix-2 shift-add datapath. start is accepted in IDLE; done pulses for one
// enabled cycle WIDTH+1 enabled edges after the start edge.
//
// Configuration macro
//   CI_MUL_HIGH_WORD_EN  defined: n selects the high (1) or low (0) product
//                        word and a 2*WIDTH accumulator is built.
//                        undefined: n is ignored, the low word is returned
//                        and only a WIDTH-bit accumulator is built.
// Ports
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-high reset
//   clk_en  in   clock enable; all state frozen when low
//   start   in   single-cycle request
//   dataa   in   multiplicand, sampled with start
//   datab   in   multiplier, sampled with start
//   n       in   word select, sampled with start
//   done    out  one-cycle completion strobe
//   result  out  product word, valid with done, held until the next result
// ---------------------------------------------------------------------------
module ci_mul_seq
    import ci_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic             n,
    output logic             done,
    output logic [WIDTH-1:0] result
);

`ifdef CI_MUL_HIGH_WORD_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              load;
    logic              step;
    logic              last;
    logic [PW-1:0]     prod_d;

`ifdef CI_MUL_HIGH_WORD_EN
    logic              n_q, n_d;
`else
    logic              unused_n;
    assign unused_n = n;
`endif

    ci_mul_shift_add #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_shift_add (
        .clk    (clk),
        .reset  (reset),
        .en     (clk_en),
        .load   (load),
        .step   (step),
        .dataa  (dataa),
        .datab  (datab),
        .last   (last),
        .prod_d (prod_d)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // start is ignored here and in DONE; nothing is queued.
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                    // Capture the product including the final iteration.
`ifdef CI_MUL_HIGH_WORD_EN
                    result_d = n_q ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0];
`else
                    result_d = prod_d;
`endif
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CI_MUL_HIGH_WORD_EN
    assign n_d = load ? n : n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q <= 1'b0;
        end else if (clk_en) begin
            n_q <= n_d;
        end
    end
`endif

    // done decodes from state, so freezing the state with clk_en low also
    // freezes done without stretching it over extra enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ci_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_ci_mul_seq
// Directed bench for ci_mul_seq (WIDTH=32). Expected words come from a 64-bit
// reference multiply and are queued at start, then popped when done appears.
// Honours CI_MUL_HIGH_WORD_EN for the expected word selection.
// ---------------------------------------------------------------------------
module tb_ci_mul_seq;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         clk_en = 1'b1;
    logic         start  = 1'b0;
    logic         n      = 1'b0;
    logic [W-1:0] dataa  = '0;
    logic [W-1:0] datab  = '0;
    logic         done;
    logic [W-1:0] result;

    int           compared   = 0;
    int           mismatched = 0;
    int           cyc        = 0;
    int           start_cyc  = 0;
    logic [W-1:0] sb_q[$];

    ci_mul_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .n      (n),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic nn);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`ifdef CI_MUL_HIGH_WORD_EN
        return nn ? p[2*W-1:W] : p[W-1:0];
`else
        return p[W-1:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse (also releases reset on the same negedge), queue the
    // expected word, then scramble the operand inputs to prove they were latched.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic nn);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        dataa = a;
        datab = b;
        n     = nn;
        sb_q.push_back(model(a, b, nn));
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        dataa = $urandom;
        datab = $urandom;
        n     = ~nn;
    endtask

    // Wait for done, check latency (edges from start edge to the edge that
    // samples done high), result, one-cycle strobe and result hold. A nonzero
    // freeze drops clk_en for that many edges while done is high.
    task automatic wait_done(input string tag, input int exp_lat, input int freeze);
        bit           got;
        int           lat;
        logic [W-1:0] exp;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 64'(got), 64'd1);
        if (got) begin
            lat = cyc - start_cyc + 1;
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            check({tag, "_result"}, 64'(result), 64'(exp));
            if (freeze > 0) begin
                clk_en = 1'b0;
                repeat (freeze) @(posedge clk);
                #1;
                check({tag, "_done_frozen"}, 64'(done), 64'd1);
                @(negedge clk);
                clk_en = 1'b1;
            end
            @(posedge clk);
            #1;
            check({tag, "_done_drop"}, 64'(done), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_hold"}, 64'(result), 64'(exp));
        end
    endtask

    initial begin
        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);

        // First start on the first enabled edge after reset release.
        start_op(32'd1, 32'd2, 1'b0);
        wait_done("mul_1x2", 33, 0);

        start_op(32'd332, 32'd22, 1'b0);
        wait_done("mul_332x22", 33, 0);
        start_op(32'd2, 32'd23, 1'b0);
        wait_done("mul_2x23", 33, 0);

        // All-ones operands, both words.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("ones_lo", 33, 0);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("ones_hi", 33, 0);

        // 2^16 * 2^16: high word 1 with the macro, 0 without.
        start_op(32'd65536, 32'd65536, 1'b1);
        wait_done("p2_32_hi", 33, 0);
        start_op(32'd65536, 32'd65536, 1'b0);
        wait_done("p2_32_lo", 33, 0);

        // Zero operand: no early exit.
        start_op(32'd0, 32'd12345, 1'b0);
        wait_done("zero_a", 33, 0);

        // clk_en low for 5 edges mid-BUSY plus start pulses while busy.
        start_op(32'd1000, 32'd3000, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        start  = 1'b1;
        dataa  = 32'd5;
        datab  = 32'd5;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("clk_en_gap", 38, 0);

        // done frozen while clk_en is low, then drops after one enabled edge.
        start_op(32'd123, 32'd456, 1'b0);
        wait_done("done_freeze", 33, 3);

        // Reset at iteration 10 discards the operation.
        start_op(32'd9, 32'd9, 1'b0);
        void'(sb_q.pop_back());
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_result_held", 64'(result), 64'd0);
        start_op(32'd7, 32'd6, 1'b0);
        wait_done("mul_7x6", 33, 0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ci_mul_seq.md
CI_MUL_SEQ -- requirements
Module: ci_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port clk_en  input  1  clock enable; when low, all state is frozen.
REQ-005 SHALL have port start  input  1  single-cycle request from the Nios II custom-instruction master.
REQ-006 SHALL have port dataa  input  WIDTH  multiplicand, sampled with start.
REQ-007 SHALL have port datab  input  WIDTH  multiplier, sampled with start.
REQ-008 SHALL have port n  input  1  word select (0 = low word, 1 = high word), sampled with start.
REQ-009 SHALL have port done  output  1  one-cycle completion strobe.
REQ-010 SHALL have port result  output  WIDTH  product word, valid when done is high.

Function
REQ-011 SHALL compute the unsigned 2*WIDTH-bit product dataa*datab by radix-2 shift-add, one operand bit per enabled cycle.
REQ-012 SHALL implement states IDLE, BUSY and DONE.
REQ-013 SHALL, in IDLE, on an edge with clk_en=1 and start=1, latch dataa, datab and n, clear the accumulator, load the bit counter with WIDTH, and enter BUSY.
REQ-014 SHALL, in BUSY, perform one iteration per enabled edge and enter DONE on the edge that completes iteration WIDTH.
REQ-015 SHALL, in DONE, drive done=1 for exactly one enabled cycle, then return to IDLE.
REQ-016 SHALL give a latency of WIDTH+1 enabled edges from the start edge to the edge at which done is first sampled high; for WIDTH=32 this is 33 edges.
REQ-017 SHALL drive result with product[WIDTH-1:0] when the latched n=0, and with product[2*WIDTH-1:WIDTH] when n=1 (see REQ-025).
REQ-018 SHALL hold result stable from done until the next accepted start.
REQ-019 SHALL ignore start while in BUSY or DONE; no queuing.
REQ-020 SHALL, when clk_en=0, hold state, counter, accumulator, done and result unchanged, and SHALL NOT extend done beyond one enabled cycle.
REQ-021 SHALL produce a correct result for zero operands without early termination; latency is constant.

Reset
REQ-022 SHALL, on reset assertion at any time (including mid-BUSY), immediately force state=IDLE, done=0, result=0, counter=0 and accumulator=0; the in-flight operation is discarded.
REQ-023 SHALL accept a new start on the first enabled edge after reset deasserts.

Configuration
REQ-024 SHALL compile the high-word select in only when macro CI_MUL_HIGH_WORD_EN is defined.
REQ-025 SHALL, with CI_MUL_HIGH_WORD_EN defined, honour n as in REQ-017; without it, keep port n present but ignore it, always return the low word, and implement only a WIDTH-bit accumulator.

Structure
REQ-026 SHALL take the state enumeration (IDLE/BUSY/DONE), the default-width constant and the counter-width function from shared package ci_mul_pkg.
REQ-027 SHALL place the shift-add datapath (accumulator, shifted operands, counter) in sub-module ci_mul_shift_add; the FSM and handshake remain in ci_mul_seq.

Verification
REQ-028 SHALL verify: reset, then start with dataa=1, datab=2, n=0 -> done exactly 33 edges later, result=32'd2.
REQ-029 SHALL verify: dataa=332, datab=22, n=0 -> result=32'd7304; then dataa=2, datab=23 back-to-back after done -> result=32'd46.
REQ-030 SHALL verify: dataa=32'hFFFFFFFF, datab=32'hFFFFFFFF -> n=0 gives 32'h00000001, n=1 gives 32'hFFFFFFFE (n=1 case only with CI_MUL_HIGH_WORD_EN defined).
REQ-031 SHALL verify: dataa=65536, datab=65536, n=1 with the macro -> result=32'h00000001; the same stimulus without the macro -> result=32'h00000000.
REQ-032 SHALL verify: clk_en held low for 5 cycles mid-BUSY -> done delayed by exactly 5 edges; a start pulse during BUSY has no effect on the result.
REQ-033 SHALL verify: reset asserted at iteration 10 -> done=0 and result=0 immediately; a fresh start of 7*6 -> result=32'd42 after 33 edges.
